// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// default line settings and the bit-period helper.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 50_000_000;
  localparam int unsigned BAUD_DEFAULT     = 115_200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = ST_IDLE,
    StStart  = ST_START,
    StData   = ST_DATA,
    StParity = ST_PARITY,
    StStop   = ST_STOP
  } tx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. Read data is the head
// entry, valid whenever o_empty is low.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AddrW:0]   o_level
);

  localparam logic [AddrW:0] DepthCount = (AddrW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW:0]   r_wr_ptr;
  logic [AddrW:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: Depth must be a power of two >= 2");
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == DepthCount);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AddrW-1:0]];

  // Pointer update; full-push and empty-pop are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes pushed over valid/ready into a FIFO are
// sent LSB-first as 8N1 frames on txd_o. Defining UART_TX_PARITY_EN adds an
// even-parity bit between the data and stop bits (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LevelW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  input  logic [7:0]        wr_data_i,
  output logic              wr_ready_o,
  output logic              txd_o,
  output logic              busy_o,
  output logic [LevelW-1:0] level_o
);

  localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BaudW = $clog2(Div);
  localparam logic [BaudW-1:0] DivLast = BaudW'(Div - 1);

  if (Div < 4) begin : g_div_check
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 4");
  end

  tx_state_e         r_state;
  tx_state_e         w_state_d;
  logic [BaudW-1:0]  r_baud;
  logic [BaudW-1:0]  w_baud_d;
  logic [2:0]        r_bit;
  logic [2:0]        w_bit_d;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_d;
  logic              r_txd;
  logic              w_txd_d;
  logic              r_busy;
  logic              w_busy_d;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
  logic              w_par_d;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_tick;
  logic [7:0]        w_fifo_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [LevelW-1:0] w_level;
  logic [LevelW-1:0] w_level_d;

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_push  (w_push),
    .i_wdata (wr_data_i),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  assign wr_ready_o = !w_fifo_full;
  assign w_push     = wr_valid_i && wr_ready_o;
  assign w_tick     = (r_baud == DivLast);
  assign w_level_d  = w_level + LevelW'(w_push) - LevelW'(w_pop);
  assign txd_o      = r_txd;
  assign busy_o     = r_busy;
  assign level_o    = w_level;

  // Next-state: frame sequencing, baud/bit counters and shifter.
  always_comb begin
    w_state_d = r_state;
    w_baud_d  = w_tick ? '0 : r_baud + 1'b1;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_d   = r_par;
`endif
    unique case (r_state)
      StIdle: begin
        w_baud_d = '0;
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_fifo_data;
`ifdef UART_TX_PARITY_EN
          w_par_d   = ^w_fifo_data;
`endif
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_bit_d   = '0;
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_tick) w_state_d = StStop;
      end
`endif
      StStop: begin
        if (w_tick) begin
          // Chain straight into the next start bit when more data is queued.
          if (!w_fifo_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_fifo_data;
`ifdef UART_TX_PARITY_EN
            w_par_d   = ^w_fifo_data;
`endif
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_baud_d  = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // Line level for the current state; registered so txd_o lags state by one cycle.
  always_comb begin
    w_txd_d = 1'b1;
    unique case (r_state)
      StIdle:   w_txd_d = 1'b1;
      StStart:  w_txd_d = 1'b0;
      StData:   w_txd_d = r_shift[0];
`ifdef UART_TX_PARITY_EN
      StParity: w_txd_d = r_par;
`endif
      StStop:   w_txd_d = 1'b1;
      default:  w_txd_d = 1'b1;
    endcase
    w_busy_d = (w_state_d != StIdle) || (w_level_d != '0);
  end

  // State, counters, shifter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_txd   <= w_txd_d;
      r_busy  <= w_busy_d;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter; host/bench-side driver for the SoC's serial inputs (dbg_txd_i debug bridge, uart_rx_i peripheral UART).
- Accepts bytes over a valid/ready push interface into a small FIFO and serialises them LSB-first on txd_o.
- Used in simulation to load and debug the TCM SoC, and in the SoC as the transmit half of the peripheral UART.

Parameters:
- CLK_FREQ, 50000000, clk_i frequency in Hz.
- BAUD, 115200, line rate. Bit period DIV = CLK_FREQ/BAUD (integer, truncated; 434 at defaults). Elaboration error if DIV < 4.
- FIFO_DEPTH, 16, byte entries. Power of two, >= 2.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-low reset.
- wr_valid_i  in  1  push request.
- wr_data_i  in  8  byte to send.
- wr_ready_o  out  1  FIFO not full.
- txd_o  out  1  serial line, idle high.
- busy_o  out  1  shifter active or FIFO non-empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i low at a clk_i edge):
  - txd_o=1, busy_o=0, level_o=0, wr_ready_o=1 (combinational from level).
  - FIFO pointers, baud counter, bit counter and FSM cleared.
  - Reset mid-frame truncates the frame; the line returns high on the next edge. Queued bytes are discarded.
- Push: a byte is written when wr_valid_i && wr_ready_o at an edge. wr_ready_o = (level != FIFO_DEPTH). A push while full is ignored, and data must be held by the source.
- FIFO:
  - Circular buffer with wrap-around read/write pointers one bit wider than the address.
  - Simultaneous push and pop when non-empty leaves level unchanged.
  - A push into an empty FIFO becomes visible to the FSM on the next cycle; there is no fall-through bypass.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd_o=1. When level != 0, pop the head into the shift register and enter START. txd_o falls on the edge after the pop.
  - Result: first start bit drives low 2 cycles after the accepting edge, when starting from idle with an empty FIFO.
  - START: txd_o=0 for DIV cycles.
  - DATA: 8 bits LSB-first, DIV cycles each; bit counter 0..7.
  - STOP: txd_o=1 for DIV cycles.
  - At the end of STOP: if level != 0, pop and go directly to START (back-to-back frames, no extra idle). Otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*DIV cycles.
  - Baud counter counts 0..DIV-1 and reloads at each bit boundary.
  - txd_o is always registered (glitch-free).
- busy_o = (state != IDLE) || (level != 0). It is registered on the same edge as the state.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP, lasting DIV cycles, driving the even parity (XOR of the 8 data bits).
  - Frame becomes 11*DIV cycles (8E1).
- Undefined: no PARITY state, 8N1, 10*DIV-cycle frame.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - the DIV computation function;
  - the default CLK_FREQ/BAUD constants.
- Sub-module sync_fifo (parameterised width/depth; push/pop/full/empty/level) instantiated once. The FSM, baud counter and shifter stay in uart_tx_fifo.

Test Plan:
- Reset: hold rst_i=0 for 5 cycles -> txd_o=1, busy_o=0, level_o=0, wr_ready_o=1.
- Single byte 0x55 at defaults -> txd_o low exactly 2 cycles after the accept edge. Line samples at the mid-point of each bit (217 + k*434 cycles): 0,1,0,1,0,1,0,1,0,1. busy_o drops 4340+1 cycles after the start edge.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles -> two frames with no idle gap. Second start bit begins exactly 4340 cycles after the first. Decoded bytes are 0xA3, 0x0F.
- Full/wrap: push 17 bytes 0x00..0x10 with wr_valid_i held.
  - wr_ready_o deasserts after 16 accepted, or 17 if the first pop has occurred.
  - All bytes appear in order; pointers wrap without loss or duplication.
  - level_o never exceeds 16.
- Reset mid-frame: assert rst_i=0 during bit 4 of 0xFF with 3 bytes queued -> txd_o=1 on the next edge, level_o=0, no further frames after release.
- UART_TX_PARITY_EN build: send 0x07 -> parity bit = 1, frame = 4774 cycles. Send 0x03 -> parity bit = 0.
